// File: rtl/waveform_analyzer.sv
// Waveform analyzer: receive side of the function-generator sample stream.
// Detects rising threshold crossings (with hysteresis) and reports period,
// high time, minimum and maximum sample of each completed waveform cycle.
module waveform_analyzer #(
  parameter logic [15:0] HYST = 16'd64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [15:0] sample,
  input  logic        sample_valid,
  input  logic [15:0] threshold,
  output logic [15:0] period,
  output logic [15:0] high_time,
  output logic [15:0] min_val,
  output logic [15:0] max_val,
  output logic        result_valid,
  output logic        locked,
  output logic        overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        level_q, level_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] hcnt_q, hcnt_d;
  logic [15:0] mn_q, mn_d;
  logic [15:0] mx_q, mx_d;
  logic [15:0] period_q, period_d;
  logic [15:0] high_time_q, high_time_d;
  logic [15:0] min_val_q, min_val_d;
  logic [15:0] max_val_q, max_val_d;
  logic        result_valid_q, result_valid_d;
  logic        locked_q, locked_d;
  logic        overflow_q, overflow_d;

  logic [16:0] hi_sum_s;
  logic [15:0] hi_th_s;
  logic [15:0] lo_th_s;
  logic        rise_s;

  // Saturating hysteresis thresholds and level detector on accepted samples
  always_comb begin
    hi_sum_s = {1'b0, threshold} + {1'b0, HYST};
    if (hi_sum_s[16]) begin
      hi_th_s = 16'hFFFF;
    end else begin
      hi_th_s = hi_sum_s[15:0];
    end
    if (threshold >= HYST) begin
      lo_th_s = threshold - HYST;
    end else begin
      lo_th_s = 16'h0000;
    end
    level_d = level_q;
    if (!sample_valid) begin
      level_d = level_q;
    end else if (!level_q && (sample >= hi_th_s)) begin
      level_d = 1'b1;
    end else if (level_q && (sample < lo_th_s)) begin
      level_d = 1'b0;
    end else begin
      level_d = level_q;
    end
    rise_s = sample_valid & ~level_q & level_d;
  end

  // Measurement FSM: next state, running counters and result registers
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    hcnt_d         = hcnt_q;
    mn_d           = mn_q;
    mx_d           = mx_q;
    period_d       = period_q;
    high_time_d    = high_time_q;
    min_val_d      = min_val_q;
    max_val_d      = max_val_q;
    result_valid_d = 1'b0;
    locked_d       = locked_q;
    overflow_d     = overflow_q;
    case (state_q)
      IDLE: begin
        cnt_d  = 16'h0000;
        hcnt_d = 16'h0000;
        mn_d   = 16'h0000;
        mx_d   = 16'h0000;
        if (enable) begin
          state_d = ARM;
        end else begin
          state_d = IDLE;
        end
      end
      ARM: begin
        if (rise_s) begin
          cnt_d   = 16'd1;
          hcnt_d  = 16'd1;
          mn_d    = sample;
          mx_d    = sample;
          state_d = MEAS;
        end else begin
          state_d = ARM;
        end
      end
      MEAS: begin
        if (rise_s) begin
          // Close the cycle; the rise sample opens the next one as sample 1
          period_d       = cnt_q;
          high_time_d    = hcnt_q;
          min_val_d      = mn_q;
          max_val_d      = mx_q;
          result_valid_d = 1'b1;
          locked_d       = 1'b1;
          overflow_d     = 1'b0;
          cnt_d          = 16'd1;
          hcnt_d         = 16'd1;
          mn_d           = sample;
          mx_d           = sample;
        end else if (sample_valid) begin
          if (cnt_q == 16'hFFFF) begin
            // No crossing within a full counter span: give up and re-arm
            overflow_d = 1'b1;
            locked_d   = 1'b0;
            cnt_d      = 16'h0000;
            hcnt_d     = 16'h0000;
            state_d    = ARM;
          end else begin
            cnt_d = cnt_q + 16'd1;
            if (level_d) begin
              hcnt_d = hcnt_q + 16'd1;
            end else begin
              hcnt_d = hcnt_q;
            end
            if (sample < mn_q) begin
              mn_d = sample;
            end else begin
              mn_d = mn_q;
            end
            if (sample > mx_q) begin
              mx_d = sample;
            end else begin
              mx_d = mx_q;
            end
          end
        end else begin
          state_d = MEAS;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Disable wins over everything, including a coincident rise
    if (!enable) begin
      state_d        = IDLE;
      locked_d       = 1'b0;
      result_valid_d = 1'b0;
      period_d       = period_q;
      high_time_d    = high_time_q;
      min_val_d      = min_val_q;
      max_val_d      = max_val_q;
      overflow_d     = overflow_q;
      cnt_d          = 16'h0000;
      hcnt_d         = 16'h0000;
      mn_d           = 16'h0000;
      mx_d           = 16'h0000;
    end else begin
      state_d = state_d;
    end
  end

  // State and result registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      level_q        <= 1'b0;
      cnt_q          <= 16'h0000;
      hcnt_q         <= 16'h0000;
      mn_q           <= 16'h0000;
      mx_q           <= 16'h0000;
      period_q       <= 16'h0000;
      high_time_q    <= 16'h0000;
      min_val_q      <= 16'h0000;
      max_val_q      <= 16'h0000;
      result_valid_q <= 1'b0;
      locked_q       <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      level_q        <= level_d;
      cnt_q          <= cnt_d;
      hcnt_q         <= hcnt_d;
      mn_q           <= mn_d;
      mx_q           <= mx_d;
      period_q       <= period_d;
      high_time_q    <= high_time_d;
      min_val_q      <= min_val_d;
      max_val_q      <= max_val_d;
      result_valid_q <= result_valid_d;
      locked_q       <= locked_d;
      overflow_q     <= overflow_d;
    end
  end

  assign period       = period_q;
  assign high_time    = high_time_q;
  assign min_val      = min_val_q;
  assign max_val      = max_val_q;
  assign result_valid = result_valid_q;
  assign locked       = locked_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_waveform_analyzer.sv
// Directed self-checking bench for waveform_analyzer.
module tb_waveform_analyzer;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [15:0] sample;
  logic        sample_valid;
  logic [15:0] threshold;
  logic [15:0] period;
  logic [15:0] high_time;
  logic [15:0] min_val;
  logic [15:0] max_val;
  logic        result_valid;
  logic        locked;
  logic        overflow;

  int n_checks;
  int n_errors;
  int cyc;
  int last_pulse;

  waveform_analyzer #(.HYST(16'd64)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .sample(sample),
    .sample_valid(sample_valid), .threshold(threshold), .period(period),
    .high_time(high_time), .min_val(min_val), .max_val(max_val),
    .result_valid(result_valid), .locked(locked), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running clock counter for pulse spacing
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present one input for one clock; outputs settle #1 after the edge
  task automatic send(input logic [15:0] s, input logic v);
    sample = s;
    sample_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic check_result(input string tag, input logic [15:0] p, input logic [15:0] h,
                              input logic [15:0] mn, input logic [15:0] mx);
    check_eq({tag, "_period"}, period, p);
    check_eq({tag, "_high"}, high_time, h);
    check_eq({tag, "_min"}, min_val, mn);
    check_eq({tag, "_max"}, max_val, mx);
  endtask

  // Square wave 3 x 0100 then 5 x F000; rise is sample index 3 of each period
  task automatic run_square(input string tag, input int periods, input bit gapped);
    logic exp_rv;
    for (int p = 0; p < periods; p++) begin
      for (int k = 0; k < 8; k++) begin
        send((k < 3) ? 16'h0100 : 16'hF000, 1'b1);
        exp_rv = (k == 3) && (p >= 1);
        check_eq({tag, "_rv"}, {15'd0, result_valid}, {15'd0, exp_rv});
        if (exp_rv) begin
          check_result(tag, 16'd8, 16'd5, 16'h0100, 16'hF000);
          check_eq({tag, "_locked"}, {15'd0, locked}, 16'd1);
          check_eq({tag, "_ovf"}, {15'd0, overflow}, 16'd0);
          if (gapped && last_pulse >= 0)
            check_eq({tag, "_spacing"}, 16'(cyc - last_pulse), 16'd16);
          last_pulse = cyc;
        end
        if (gapped) begin
          // Invalid slot carries a value that would otherwise cross the threshold
          send((k < 3) ? 16'hFFFF : 16'h0000, 1'b0);
          check_eq({tag, "_rv_gap"}, {15'd0, result_valid}, 16'd0);
        end
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    cyc = 0;
    last_pulse = -1;
    rst_n = 1'b0;
    enable = 1'b0;
    sample = 16'h0000;
    sample_valid = 1'b0;
    threshold = 16'h8000;
    send(16'h0000, 1'b0);
    send(16'h0000, 1'b0);
    check_result("reset", 16'd0, 16'd0, 16'd0, 16'd0);
    check_eq("reset_rv", {15'd0, result_valid}, 16'd0);
    check_eq("reset_locked", {15'd0, locked}, 16'd0);
    check_eq("reset_ovf", {15'd0, overflow}, 16'd0);

    // Square wave, continuous valid
    rst_n = 1'b1;
    enable = 1'b1;
    send(16'h0000, 1'b0);
    run_square("sq", 4, 1'b0);

    // Disable: locked drops, data holds
    enable = 1'b0;
    send(16'h0100, 1'b1);
    check_eq("dis_locked", {15'd0, locked}, 16'd0);
    check_eq("dis_period", period, 16'd8);
    check_eq("dis_rv", {15'd0, result_valid}, 16'd0);

    // Reset in the middle of a measurement with cnt = 37
    enable = 1'b1;
    send(16'h0100, 1'b1);
    send(16'hF000, 1'b1);
    for (int i = 0; i < 36; i++) send(16'hF000, 1'b1);
    rst_n = 1'b0;
    send(16'h0100, 1'b1);
    check_result("midrst", 16'd0, 16'd0, 16'd0, 16'd0);
    check_eq("midrst_rv", {15'd0, result_valid}, 16'd0);
    check_eq("midrst_locked", {15'd0, locked}, 16'd0);
    check_eq("midrst_ovf", {15'd0, overflow}, 16'd0);

    // Same square wave with every other clock invalid
    rst_n = 1'b1;
    send(16'h0000, 1'b0);
    last_pulse = -1;
    run_square("gap", 4, 1'b1);

    // Hysteresis band 7FC0..803F around 8000
    rst_n = 1'b0;
    send(16'h0000, 1'b0);
    rst_n = 1'b1;
    send(16'h0000, 1'b0);
    send(16'h8010, 1'b1);
    send(16'h7FD0, 1'b1);
    send(16'h8030, 1'b1);
    send(16'h8040, 1'b1);
    check_eq("hyst_rv0", {15'd0, result_valid}, 16'd0);
    send(16'h7FC0, 1'b1);
    send(16'h7FBF, 1'b1);
    send(16'h803F, 1'b1);
    check_eq("hyst_rv1", {15'd0, result_valid}, 16'd0);
    send(16'h8040, 1'b1);
    check_eq("hyst_rv", {15'd0, result_valid}, 16'd1);
    check_result("hyst", 16'd4, 16'd2, 16'h7FBF, 16'h8040);

    // Constant input after a rise: overflow after 65535 further samples
    for (int i = 0; i < 65534; i++) send(16'h9000, 1'b1);
    check_eq("pre_ovf", {15'd0, overflow}, 16'd0);
    check_eq("pre_ovf_locked", {15'd0, locked}, 16'd1);
    send(16'h9000, 1'b1);
    check_eq("ovf", {15'd0, overflow}, 16'd1);
    check_eq("ovf_locked", {15'd0, locked}, 16'd0);
    check_eq("ovf_rv", {15'd0, result_valid}, 16'd0);
    check_result("ovf", 16'd4, 16'd2, 16'h7FBF, 16'h8040);
    // Back in ARM: first rise only arms, next completed cycle clears overflow
    for (int k = 0; k < 8; k++) send((k < 3) ? 16'h0100 : 16'hF000, 1'b1);
    check_eq("rearm_ovf", {15'd0, overflow}, 16'd1);
    for (int k = 0; k < 4; k++) send((k < 3) ? 16'h0100 : 16'hF000, 1'b1);
    check_eq("rearm_rv", {15'd0, result_valid}, 16'd1);
    check_eq("rearm_ovf_clr", {15'd0, overflow}, 16'd0);
    check_eq("rearm_locked", {15'd0, locked}, 16'd1);
    check_result("rearm", 16'd8, 16'd5, 16'h0100, 16'hF000);

    // High threshold saturates hi_th at FFFF
    rst_n = 1'b0;
    send(16'h0000, 1'b0);
    rst_n = 1'b1;
    threshold = 16'hFFF0;
    send(16'h0000, 1'b0);
    send(16'h0000, 1'b1);
    send(16'hFFFF, 1'b1);
    send(16'h0000, 1'b1);
    send(16'hFFFE, 1'b1);
    send(16'hFFFF, 1'b1);
    check_eq("sat_hi_rv", {15'd0, result_valid}, 16'd1);
    check_result("sat_hi", 16'd3, 16'd1, 16'h0000, 16'hFFFF);

    // Low threshold saturates lo_th at 0: level never falls
    rst_n = 1'b0;
    send(16'h0000, 1'b0);
    rst_n = 1'b1;
    threshold = 16'h0010;
    send(16'h0000, 1'b0);
    send(16'h0000, 1'b1);
    send(16'h0060, 1'b1);
    for (int i = 0; i < 6; i++) begin
      send((i % 2 == 0) ? 16'h0000 : 16'h0060, 1'b1);
      check_eq("sat_lo_rv", {15'd0, result_valid}, 16'd0);
    end
    check_eq("sat_lo_locked", {15'd0, locked}, 16'd0);
    check_eq("sat_lo_period", period, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
